barret_211_arbiter: RTL

BARRET_211_ARBITER -- requirements
Module: barret_211_arbiter

---
 rtl/barret_211_pkg.sv | 16 +
 rtl/barret_for_211.sv | 28 ++
 rtl/barret_211_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/barret_211_pkg.sv
// Shared constants and FSM state type for the mod-211 reduction arbiter.
package barret_211_pkg;

  localparam int unsigned MOD_P   = 211;
  localparam int unsigned OP_W    = 15;
  localparam int unsigned RES_W   = 8;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    RESP
  } state_e;

endpackage

// File: rtl/barret_for_211.sv
// Combinational Barrett reduction of a 15-bit operand modulo 211.
module barret_for_211
  import barret_211_pkg::*;
(
  input  logic [OP_W-1:0]  din_a,
  output logic [RES_W-1:0] dout_r
);

  localparam int unsigned K = 16;
  localparam int unsigned M = (2 ** K) / MOD_P;

  logic [23:0]     prod;
  logic [OP_W-1:0] qm;
  logic [OP_W-1:0] rem;

  // M underestimates 2^K/211, so the quotient is low by at most one:
  // a single conditional subtract completes the reduction.
  always_comb begin
    prod = 24'(din_a) * 24'(M);
    qm   = OP_W'((prod >> K) * 24'(MOD_P));
    rem  = din_a - qm;
    if (rem >= OP_W'(MOD_P)) begin
      rem = rem - OP_W'(MOD_P);
    end
    dout_r = RES_W'(rem);
  end

endmodule

// File: rtl/barret_211_arbiter.sv
// Round-robin arbiter time-sharing one mod-211 reducer among four requesters.
module barret_211_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_REQ-1:0]                      req_valid,
  input  logic [NUM_REQ*barret_211_pkg::OP_W-1:0] req_data,
  output logic [NUM_REQ-1:0]                      req_ready,
  output logic                                    resp_valid,
  output logic [barret_211_pkg::RES_W-1:0]        resp_data,
  output logic [barret_211_pkg::ID_W-1:0]         resp_id,
  input  logic                                    resp_ready,
  output logic [CNT_W-1:0]                        done_cnt
);

  import barret_211_pkg::*;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              boot_q;
  logic [RES_W-1:0]  red_out;
  logic              hit;
  logic [ID_W-1:0]   gnt;

  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    ptr);
    logic            found;
    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] idx;
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'(32'(ptr) + i);
      if (!found && valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return {found, sel};
  endfunction

  barret_for_211 u_red (
    .din_a  (op_q),
    .dout_r (red_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      op_q    <= '0;
      id_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      boot_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      op_q    <= op_d;
      id_q    <= id_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      boot_q  <= 1'b0;
    end
  end

  // Grants are masked while rst is high and for the first cycle after it.
  always_comb begin
    {hit, gnt} = rr_pick(req_valid, rr_q);
    state_d    = state_q;
    rr_d       = rr_q;
    op_d       = op_q;
    id_d       = id_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    req_ready  = '0;
    resp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit && !rst && !boot_q) begin
          req_ready[gnt] = 1'b1;
          op_d           = req_data[gnt*OP_W +: OP_W];
          id_d           = gnt;
          state_d        = REDUCE;
        end
      end
      REDUCE: begin
        res_d   = red_out;
        state_d = RESP;
      end
      RESP: begin
        resp_valid = !rst;
        if (resp_ready) begin
          rr_d    = id_q + ID_W'(1);
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_data = res_q;
  assign resp_id   = id_q;
  assign done_cnt  = cnt_q;

endmodule
